operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
- Decode-to-execute boundary stage directly downstream of the 16x32 register file.
- Takes the three register-file read ports (PA/PB/PC) plus decode control and resolves data hazards by forwarding from EX, MEM and WB.
- Detects load-use hazards and stalls decode for one cycle.
- Latches resolved operands and control into the ID/EX pipeline register that feeds the ALU/shifter.

Parameters:
- DATA_W, 32, operand/data width
- ADDR_W, 4, register address width (16 registers)
- CTRL_W, 12, opaque decode control bundle width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- FLUSH  in  1  branch taken; squash the instruction entering EX
- ID_VALID  in  1  decode slot holds a real instruction
- ID_CTRL  in  CTRL_W  decode control bundle
- ID_RA, ID_RB, ID_RC  in  ADDR_W each  source register numbers (also drive register-file RA/RB/RC)
- ID_USE  in  3  bit0/1/2 = operand A/B/C actually used
- ID_RD  in  ADDR_W  destination register
- ID_PC8  in  DATA_W  PC+8 of the decode instruction
- RF_PA, RF_PB, RF_PC  in  DATA_W each  register-file read data
- EX_FWD_WE, EX_FWD_LOAD  in  1 each  EX instruction writes a register / is a load
- EX_FWD_RD  in  ADDR_W  EX destination register
- EX_FWD_DATA  in  DATA_W  EX result
- MEM_FWD_WE  in  1  MEM instruction writes a register
- MEM_FWD_RD  in  ADDR_W  MEM destination register
- MEM_FWD_DATA  in  DATA_W  MEM result
- WB_FWD_WE  in  1  WB write enable (same net as register-file E)
- WB_FWD_RD  in  ADDR_W  WB destination (same net as RW)
- WB_FWD_DATA  in  DATA_W  WB data (same net as PW)
- STALL  out  1  hold PC and IF/ID this cycle
- EX_VALID  out  1  ID/EX register holds a real instruction
- EX_CTRL  out  CTRL_W  latched control
- EX_RD  out  ADDR_W  latched destination register
- EX_OPA, EX_OPB, EX_OPC  out  DATA_W each  latched resolved operands
- STALL_CNT  out  16  saturating count of load-use stall cycles

Behaviour:
- Reset (RESET=0, asynchronous): all registered outputs are 0 (EX_VALID=0, EX_CTRL=0, EX_RD=0, operands=0, STALL_CNT=0). STALL is combinational and is forced to 0 while reset is asserted.
- Operand resolution is combinational and identical for A/B/C with source register Rx. Priority, first match wins:
  1. Rx==15 -> ID_PC8.
  2. EX_FWD_WE and !EX_FWD_LOAD and EX_FWD_RD==Rx -> EX_FWD_DATA.
  3. MEM_FWD_WE and MEM_FWD_RD==Rx -> MEM_FWD_DATA.
  4. WB_FWD_WE and WB_FWD_RD==Rx -> WB_FWD_DATA. Needed because the register file updates only at the clock edge.
  5. Otherwise -> RF_Px.
- Load-use hazard:
  - Condition: ID_VALID and EX_FWD_WE and EX_FWD_LOAD and, for some used operand x (ID_USE[x]=1), EX_FWD_RD==Rx and Rx!=15.
  - Effect: STALL=1, and a bubble is latched (EX_VALID=0, EX_CTRL=0, EX_RD=0, operands hold their previous values).
  - Next cycle the load is in MEM, so MEM forwarding resolves the operand. The stall therefore lasts exactly one cycle per load.
- FLUSH has priority over everything: latch a bubble and force STALL=0 in the same cycle.
- Normal edge (no FLUSH, no stall): EX_VALID<=ID_VALID, EX_CTRL<=ID_CTRL, EX_RD<=ID_RD, EX_OPx<=resolved operand.
- ID_VALID=0 latches a bubble and never stalls. Operands are still loaded, so their values are don't-care.
- STALL_CNT increments on every cycle with STALL=1 and saturates at 16'hFFFF.
- Unused operands (ID_USE bit 0) are still forwarded normally but never cause a stall.
- Latency: one cycle from decode inputs to EX_* outputs.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, the PC_REG=4'd15 constant, and a bubble control constant (all zeros).
- One natural sub-module: operand_forward_mux (priority select for a single operand), instantiated three times. The hazard detect, ID/EX register and counter stay in the top level.

Test Plan:
- No hazards: RF_PA=32'h11, RF_PB=32'h22, RF_PC=32'h33, all FWD_WE=0, ID_VALID=1 -> after one edge EX_OPA=32'h11, EX_OPB=32'h22, EX_OPC=32'h33, EX_VALID=1, STALL=0.
- Forward priority: ID_RA=3; EX, MEM and WB all write r3 with 32'hA, 32'hB, 32'hC -> EX_OPA=32'hA. Drop EX_FWD_WE -> EX_OPA=32'hB. Drop MEM_FWD_WE -> EX_OPA=32'hC.
- Load-use: EX_FWD_LOAD=1, EX_FWD_RD=5, ID_RB=5, ID_USE=3'b010 -> STALL=1 for one cycle, a bubble enters EX, STALL_CNT=1. Next cycle, with MEM_FWD_RD=5 and MEM_FWD_DATA=32'hDEAD -> EX_OPB=32'hDEAD, EX_VALID=1.
- The same load with ID_USE=3'b000, or with ID_RB=15 -> no stall.
- R15 read: ID_RA=15, ID_PC8=32'h108, EX_FWD_RD=15 with EX_FWD_WE=1 -> EX_OPA=32'h108.
- FLUSH asserted during a load-use hazard -> STALL=0, EX_VALID=0, STALL_CNT unchanged.
- Assert RESET=0 mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
- Force 65540 stall cycles -> STALL_CNT holds at 16'hFFFF.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// ============================================================================
// Module : operand_fetch_stage_pkg
// Brief  : Shared widths and constants for the operand fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package operand_fetch_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int CTRL_W_DEF = 12;

    // R15 reads as PC+8 rather than register-file contents
    localparam logic [3:0] PC_REG = 4'd15;

    localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL = '0;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_stage_forward_mux.sv
// ============================================================================
// Module : operand_forward_mux
// Brief  : Priority select of one source operand: PC+8, EX, MEM, WB, then RF.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module operand_forward_mux
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] rx,
    input  logic [DATA_W-1:0] pc8,
    input  logic              ex_we,
    input  logic              ex_load,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (rx == ADDR_W'(PC_REG)) begin
            operand = pc8;
        end else if (ex_we && !ex_load && (ex_rd == rx)) begin
            // a load's data does not exist yet in EX; the hazard logic stalls instead
            operand = ex_data;
        end else if (mem_we && (mem_rd == rx)) begin
            operand = mem_data;
        end else if (wb_we && (wb_rd == rx)) begin
            operand = wb_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// ============================================================================
// Module : operand_fetch_stage
// Brief  : Operand forwarding, load-use stall detection and ID/EX register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [ADDR_W-1:0] id_ra,
    input  logic [ADDR_W-1:0] id_rb,
    input  logic [ADDR_W-1:0] id_rc,
    input  logic [2:0]        id_use,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0] id_pc8,
    input  logic [DATA_W-1:0] rf_pa,
    input  logic [DATA_W-1:0] rf_pb,
    input  logic [DATA_W-1:0] rf_pc,
    input  logic              ex_fwd_we,
    input  logic              ex_fwd_load,
    input  logic [ADDR_W-1:0] ex_fwd_rd,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              mem_fwd_we,
    input  logic [ADDR_W-1:0] mem_fwd_rd,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_fwd_we,
    input  logic [ADDR_W-1:0] wb_fwd_rd,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_opa,
    output logic [DATA_W-1:0] ex_opb,
    output logic [DATA_W-1:0] ex_opc,
    output logic [15:0]       stall_cnt
);

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [ADDR_W-1:0]      w_src [3];
    logic [DATA_W-1:0]      w_rf  [3];
    logic [2:0][DATA_W-1:0] w_opnd;
    logic [2:0]             w_match;
    logic                   w_hazard;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [ADDR_W-1:0] r_rd;
    logic [2:0][DATA_W-1:0] r_op;
    logic [15:0]       r_cnt;

    assign w_src[0] = id_ra;
    assign w_src[1] = id_rb;
    assign w_src[2] = id_rc;
    assign w_rf[0]  = rf_pa;
    assign w_rf[1]  = rf_pb;
    assign w_rf[2]  = rf_pc;

    for (genvar i = 0; i < 3; i++) begin : g_opnd
        operand_forward_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_mux (
            .rx       (w_src[i]),
            .pc8      (id_pc8),
            .ex_we    (ex_fwd_we),
            .ex_load  (ex_fwd_load),
            .ex_rd    (ex_fwd_rd),
            .ex_data  (ex_fwd_data),
            .mem_we   (mem_fwd_we),
            .mem_rd   (mem_fwd_rd),
            .mem_data (mem_fwd_data),
            .wb_we    (wb_fwd_we),
            .wb_rd    (wb_fwd_rd),
            .wb_data  (wb_fwd_data),
            .rf_data  (w_rf[i]),
            .operand  (w_opnd[i])
        );

        assign w_match[i] = id_use[i] && (ex_fwd_rd == w_src[i]) &&
                            (w_src[i] != ADDR_W'(PC_REG));
    end

    assign w_hazard = id_valid && ex_fwd_we && ex_fwd_load && (|w_match);
    assign stall    = reset && !flush && w_hazard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
        end else begin
            if (stall && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 16'd1;
            end
            // bubbles leave the operand registers untouched
            if (flush || stall) begin
                r_valid <= 1'b0;
                r_ctrl  <= CTRL_W'(BUBBLE_CTRL);
                r_rd    <= '0;
            end else begin
                r_valid <= id_valid;
                r_ctrl  <= id_ctrl;
                r_rd    <= id_rd;
                r_op    <= w_opnd;
            end
        end
    end

    assign ex_valid  = r_valid;
    assign ex_ctrl   = r_ctrl;
    assign ex_rd     = r_rd;
    assign ex_opa    = r_op[0];
    assign ex_opb    = r_op[1];
    assign ex_opc    = r_op[2];
    assign stall_cnt = r_cnt;

endmodule

`default_nettype wire
